// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared 8-bit logic/arithmetic datapath.
// One operation in flight: IDLE accepts, ISSUE launches, WAIT covers DP_LAT, RESP returns.
module alu_req_arbiter #(
  parameter int unsigned DP_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [7:0] dp_a,
  output logic [7:0] dp_b,
  output logic [1:0] dp_op,
  output logic       dp_start,
  input  logic [7:0] dp_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_y,
  output logic       busy,
  output logic [1:0] o_dbg_state
);
  // Every channel transfers on a cycle where valid and ready are both high; ready is a
  // function of state and grant only, and the sender holds payload until it sees ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(DP_LAT - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_last;
  logic       r_id;
  logic [1:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_y;
  logic       r_rsp_id;
  logic [2:0] r_cnt;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_accept;
  logic       w_cnt_done;

  // On a tie the grant goes to whoever was not served last.
  assign w_gnt0     = req0_valid && (!req1_valid || r_last);
  assign w_gnt1     = req1_valid && (!req0_valid || !r_last);
  assign req0_ready = (r_state == S_IDLE) && w_gnt0 && !reset;
  assign req1_ready = (r_state == S_IDLE) && w_gnt1 && !reset;
  assign w_accept   = req0_ready || req1_ready;
  assign w_cnt_done = (r_cnt == 3'd0);

  assign dp_a        = r_a;
  assign dp_b        = r_b;
  assign dp_op       = r_op;
  assign rsp_y       = r_y;
  assign rsp_id      = r_rsp_id;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next    = r_state;
    dp_start  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        dp_start = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        if (w_cnt_done) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_op     <= 2'b00;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_y      <= 8'h00;
      r_rsp_id <= 1'b0;
      r_cnt    <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_id   <= req1_ready;
        r_last <= req1_ready;
        r_op   <= req1_ready ? req1_op : req0_op;
        r_a    <= req1_ready ? req1_a  : req0_a;
        r_b    <= req1_ready ? req1_b  : req0_b;
      end
      // Counter runs DP_LAT-1 down to 0, so WAIT lasts exactly DP_LAT cycles.
      if (r_state == S_ISSUE) begin
        r_cnt <= LAT_LOAD;
      end else if (r_state == S_WAIT && !w_cnt_done) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (r_state == S_WAIT && w_cnt_done) begin
        r_y      <= dp_y;
        r_rsp_id <= r_id;
      end
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: two instances (DP_LAT=1 and DP_LAT=3) behind registered datapath
// models, a cycle-timeline reference model with a response queue, and directed literal checks.
module tb_alu_req_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid [2];
  logic       req0_ready [2];
  logic [1:0] req0_op    [2];
  logic [7:0] req0_a     [2];
  logic [7:0] req0_b     [2];
  logic       req1_valid [2];
  logic       req1_ready [2];
  logic [1:0] req1_op    [2];
  logic [7:0] req1_a     [2];
  logic [7:0] req1_b     [2];
  logic [7:0] dp_a       [2];
  logic [7:0] dp_b       [2];
  logic [1:0] dp_op      [2];
  logic       dp_start   [2];
  logic [7:0] dp_y       [2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic       rsp_id     [2];
  logic [7:0] rsp_y      [2];
  logic       busy       [2];
  logic [1:0] dbg_state  [2];

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entries: {instance, requester id, result}.
  logic [9:0] exp_q[$];

  // Reference model: time since accept drives every expected output.
  bit         m_run  [2] = '{1'b0, 1'b0};
  int         m_age  [2] = '{0, 0};
  logic       m_last [2] = '{1'b1, 1'b1};
  logic       m_id   [2] = '{1'b0, 1'b0};
  logic       m_rid  [2] = '{1'b0, 1'b0};
  logic [1:0] m_op   [2] = '{2'b00, 2'b00};
  logic [7:0] m_a    [2] = '{8'h00, 8'h00};
  logic [7:0] m_b    [2] = '{8'h00, 8'h00};
  logic [7:0] m_ry   [2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;
    logic [7:0] pipe [L];

    alu_req_arbiter #(.DP_LAT(L)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid[gi]),
      .req0_ready (req0_ready[gi]),
      .req0_op    (req0_op[gi]),
      .req0_a     (req0_a[gi]),
      .req0_b     (req0_b[gi]),
      .req1_valid (req1_valid[gi]),
      .req1_ready (req1_ready[gi]),
      .req1_op    (req1_op[gi]),
      .req1_a     (req1_a[gi]),
      .req1_b     (req1_b[gi]),
      .dp_a       (dp_a[gi]),
      .dp_b       (dp_b[gi]),
      .dp_op      (dp_op[gi]),
      .dp_start   (dp_start[gi]),
      .dp_y       (dp_y[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_id     (rsp_id[gi]),
      .rsp_y      (rsp_y[gi]),
      .busy       (busy[gi]),
      .o_dbg_state(dbg_state[gi])
    );

    // Datapath: result is valid L cycles after dp_start, garbage (EE) otherwise.
    always @(posedge clk) begin
      pipe[0] <= dp_start[gi] ? alu_f(dp_op[gi], dp_a[gi], dp_b[gi]) : 8'hEE;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_y[gi] = pipe[L-1];
  end

  // Compare process: every cycle, both instances, all outputs.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int         g;
      int         lat;
      int         idx;
      logic       ev;
      logic       eid;
      logic [7:0] ey;
      logic [31:0] act;
      logic [31:0] exp;
      lat = (k == 0) ? 1 : 3;
      g = -1;
      if (!m_run[k] && !reset) begin
        if (req0_valid[k] && (!req1_valid[k] || m_last[k])) g = 0;
        else if (req1_valid[k]) g = 1;
      end
      ev  = m_run[k] && (m_age[k] >= lat + 2);
      ey  = ev ? alu_f(m_op[k], m_a[k], m_b[k]) : m_ry[k];
      eid = ev ? m_id[k] : m_rid[k];
      act = {req0_ready[k], req1_ready[k], dp_start[k], rsp_valid[k], busy[k], rsp_id[k],
             rsp_y[k], dp_op[k], dp_a[k], dp_b[k]};
      exp = {(g == 0), (g == 1), (m_run[k] && m_age[k] == 1), ev, m_run[k], eid,
             ey, m_op[k], m_a[k], m_b[k]};
      chk($sformatf("cycle_inst%0d", k), act, exp);
      if (reset) begin
        m_run[k] = 1'b0; m_last[k] = 1'b1; m_id[k] = 1'b0; m_rid[k] = 1'b0;
        m_op[k] = 2'b00; m_a[k] = 8'h00; m_b[k] = 8'h00; m_ry[k] = 8'h00;
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i][9] == k[0]) exp_q.delete(i);
      end else if (g >= 0) begin
        m_op[k]   = (g == 1) ? req1_op[k] : req0_op[k];
        m_a[k]    = (g == 1) ? req1_a[k]  : req0_a[k];
        m_b[k]    = (g == 1) ? req1_b[k]  : req0_b[k];
        m_id[k]   = g[0];
        m_last[k] = g[0];
        m_run[k]  = 1'b1;
        m_age[k]  = 1;
        exp_q.push_back({k[0], g[0], alu_f(m_op[k], m_a[k], m_b[k])});
      end else if (m_run[k]) begin
        if (ev && rsp_ready[k]) begin
          idx = -1;
          foreach (exp_q[i]) if (idx < 0 && exp_q[i][9] == k[0]) idx = i;
          if (idx < 0) begin
            chk($sformatf("sb_unexpected_inst%0d", k), 32'({rsp_id[k], rsp_y[k]}), 32'h1FF);
          end else begin
            chk($sformatf("sb_rsp_inst%0d", k), 32'({rsp_id[k], rsp_y[k]}),
                32'(exp_q[idx][8:0]));
            exp_q.delete(idx);
          end
          m_ry[k]  = ey;
          m_rid[k] = eid;
          m_run[k] = 1'b0;
        end else begin
          m_age[k]++;
        end
      end
    end
  end

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[k] !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy[k] !== 1'b0) chk("idle_timeout", 32'(busy[k]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] t_sel [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
  logic [1:0] t_op  [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
  logic [7:0] t_a   [5] = '{8'hFF, 8'h5A, 8'h81, 8'hC3, 8'h7F};
  logic [7:0] t_b   [5] = '{8'h01, 8'hF0, 8'h18, 8'h3C, 8'h80};

  initial begin
    int         gseq[$];
    logic [7:0] y0;
    logic [7:0] y1;
    logic [3:0] gs;
    int         n;
    y0 = 8'h00;
    y1 = 8'h00;
    gs = 4'h0;
    for (int k = 0; k < 2; k++) begin
      req0_valid[k] = 1'b0; req0_op[k] = 2'b00; req0_a[k] = 8'h00; req0_b[k] = 8'h00;
      req1_valid[k] = 1'b0; req1_op[k] = 2'b00; req1_a[k] = 8'h00; req1_b[k] = 8'h00;
      rsp_ready[k]  = 1'b1;
    end
    // Reset with both requesters valid on instance 0: req0 AND F0,3C and req1 ADD FF,02.
    req0_valid[0] = 1'b1; req0_op[0] = 2'b00; req0_a[0] = 8'hF0; req0_b[0] = 8'h3C;
    req1_valid[0] = 1'b1; req1_op[0] = 2'b01; req1_a[0] = 8'hFF; req1_b[0] = 8'h02;
    @(negedge clk);
    chk("reset_outputs", 32'({req0_ready[0], req1_ready[0], dp_start[0], rsp_valid[0],
        busy[0], rsp_id[0], rsp_y[0], dp_a[0]}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("first_grant_req0", 32'({req0_ready[0], req1_ready[0]}), 32'(2'b10));

    // Fairness: both held valid, grants must alternate 0,1,0,1.
    for (int c = 0; c < 40 && gseq.size() < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (req0_ready[0]) gseq.push_back(0);
      if (req1_ready[0]) gseq.push_back(1);
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (rsp_id[0]) y1 = rsp_y[0];
        else           y0 = rsp_y[0];
      end
    end
    @(posedge clk); #1;
    req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
    foreach (gseq[i]) if (i < 4) gs[3-i] = gseq[i][0];
    chk("fair_grant_count", 32'(gseq.size()), 32'd4);
    chk("fair_grant_order", 32'(gs), 32'(4'b0101));
    chk("fair_and_result", 32'(y0), 32'h30);
    chk("fair_add_wrap", 32'(y1), 32'h01);

    // Single request on DP_LAT=1: req0 AND F0,3C.
    wait_idle(0);
    @(posedge clk); #1;
    req0_valid[0] = 1'b1; req0_op[0] = 2'b00; req0_a[0] = 8'hF0; req0_b[0] = 8'h3C;
    @(negedge clk);
    chk("single_c0_ready0", 32'(req0_ready[0]), 32'd1);
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    @(negedge clk);
    chk("single_c1_start", 32'({dp_start[0], dp_op[0], dp_a[0], dp_b[0]}),
        32'({1'b1, 2'b00, 8'hF0, 8'h3C}));
    @(negedge clk);
    chk("single_c2_no_rsp", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    chk("single_c3_rsp", 32'({rsp_valid[0], rsp_id[0], rsp_y[0]}), 32'({1'b1, 1'b0, 8'h30}));

    // Backpressure: req1 OR 50,0A with rsp_ready low; req0 waits meanwhile.
    wait_idle(0);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    req1_valid[0] = 1'b1; req1_op[0] = 2'b10; req1_a[0] = 8'h50; req1_b[0] = 8'h0A;
    @(negedge clk);
    chk("bp_accept_req1", 32'({req0_ready[0], req1_ready[0]}), 32'(2'b01));
    @(posedge clk); #1;
    req1_valid[0] = 1'b0;
    req0_valid[0] = 1'b1; req0_op[0] = 2'b11; req0_a[0] = 8'h12; req0_b[0] = 8'h34;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_hold", 32'({rsp_valid[0], rsp_id[0], rsp_y[0], req0_ready[0], req1_ready[0],
          busy[0]}), 32'({1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1}));
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_rsp", 32'(rsp_valid[0]), 32'd1);
    @(negedge clk);
    chk("bp_idle_next", 32'({busy[0], req0_ready[0]}), 32'(2'b01));
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;

    // Reset during WAIT: req0 ADD 10,20 is dropped.
    wait_idle(0);
    @(posedge clk); #1;
    req0_valid[0] = 1'b1; req0_op[0] = 2'b01; req0_a[0] = 8'h10; req0_b[0] = 8'h20;
    @(negedge clk);
    chk("midrst_accept", 32'(req0_ready[0]), 32'd1);
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_wait", 32'({busy[0], dp_start[0], rsp_valid[0]}), 32'(3'b100));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'({rsp_valid[0], busy[0], dp_start[0]}), 32'd0);
    end
    @(posedge clk); #1;
    req0_valid[0] = 1'b1; req1_valid[0] = 1'b1;
    @(negedge clk);
    chk("midrst_tie_req0", 32'({req0_ready[0], req1_ready[0]}), 32'(2'b10));
    @(posedge clk); #1;
    req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;

    // Longer latency, DP_LAT=3: req1 XOR AA,0F.
    wait_idle(1);
    @(posedge clk); #1;
    req1_valid[1] = 1'b1; req1_op[1] = 2'b11; req1_a[1] = 8'hAA; req1_b[1] = 8'h0F;
    @(negedge clk);
    chk("lat3_c0_ready1", 32'({req0_ready[1], req1_ready[1]}), 32'(2'b01));
    @(posedge clk); #1;
    req1_valid[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("lat3_c%0d_dp", c), 32'({dp_a[1], dp_b[1], dp_op[1], dp_start[1],
          rsp_valid[1]}), 32'({8'hAA, 8'h0F, 2'b11, (c == 1), 1'b0}));
    end
    @(negedge clk);
    chk("lat3_c5_rsp", 32'({rsp_valid[1], rsp_id[1], rsp_y[1]}), 32'({1'b1, 1'b1, 8'hA5}));

    // Mixed table on DP_LAT=3, including ties and one stalled response.
    for (int i = 0; i < 5; i++) begin
      wait_idle(1);
      @(posedge clk); #1;
      req0_op[1] = t_op[i]; req0_a[1] = t_a[i]; req0_b[1] = t_b[i];
      req1_op[1] = t_op[i]; req1_a[1] = t_b[i]; req1_b[1] = t_a[i] ^ 8'h0F;
      req0_valid[1] = t_sel[i][0];
      req1_valid[1] = t_sel[i][1];
      @(posedge clk); #1;
      req0_valid[1] = 1'b0; req1_valid[1] = 1'b0;
      if (i == 3) begin
        rsp_ready[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
      end
    end

    wait_idle(0);
    wait_idle(1);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
